// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: datapath width, word alignment
// constants, FSM state encoding and next-PC select codes.
package pc_sequencer_pkg;

    localparam int DATA_WIDTH = 32;

    // Instructions are word aligned; the PC advances one word per transfer.
    localparam int                    ALIGN_BITS = 2;
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(1) << ALIGN_BITS;
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-ALIGN_BITS){1'b1}},
                                                    {ALIGN_BITS{1'b0}}};

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_ISSUE  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PCSEL_HOLD  = 2'd0,
        PCSEL_INC   = 2'd1,
        PCSEL_REDIR = 2'd2,
        PCSEL_TRAP  = 2'd3
    } pcsel_t;

endpackage

// File: rtl/pc_sequencer_pc_next_sel.sv
// pc_next_sel: combinational next-PC selector.
// Ports:
//   i_rst      reset active, forces RESET_VECTOR
//   i_sel      select code (hold / +step / redirect / trap)
//   i_pc       current PC
//   i_target   redirect destination (low bits are cleared to word alignment)
//   o_pc_next  selected next PC
module pc_next_sel
    import pc_sequencer_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = DATA_WIDTH'(32'h0000_0100)
) (
    input  logic                  i_rst,
    input  pcsel_t                i_sel,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_target,
    output logic [DATA_WIDTH-1:0] o_pc_next
);

    always_comb begin
        o_pc_next = i_pc;
        if (i_rst) begin
            o_pc_next = RESET_VECTOR;
        end else begin
            case (i_sel)
                PCSEL_HOLD:  o_pc_next = i_pc;
                // Addition wraps naturally at 2^DATA_WIDTH.
                PCSEL_INC:   o_pc_next = i_pc + PC_STEP;
                PCSEL_REDIR: o_pc_next = i_target & ALIGN_MASK;
                PCSEL_TRAP:  o_pc_next = TRAP_VECTOR;
                default:     o_pc_next = i_pc;
            endcase
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/issue sequencer. Fetches one instruction word at the
// current PC, offers it to decode with a valid/ready handshake, then
// advances the PC. Trap, redirect and halt override normal sequencing in
// that priority order.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req/imem_addr       fetch request (level) and address
//   imem_ready/imem_rdata    one-cycle fetch response and data
//   inst_valid/inst_ready    decode handshake
//   inst_out/inst_pc         offered instruction and its PC
//   redirect/redirect_target branch/jump taken and destination
//   trap, halt               trap entry, stop fetching
//   pc_out                   architectural PC
//   issue_cnt                count of accepted instructions (wraps)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = DATA_WIDTH'(32'h0000_0100)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [DATA_WIDTH-1:0] inst_pc,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    input  logic                  trap,
    input  logic                  halt,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] issue_cnt
);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [DATA_WIDTH-1:0] r_inst_pc;
    logic [DATA_WIDTH-1:0] r_cnt;
    // Set on the first clock edge after reset release, so the fetch request
    // appears one cycle after rst drops rather than combinationally with it.
    logic                  r_run;

    state_t                w_state_next;
    pcsel_t                w_pcsel;
    logic                  w_latch;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_pc_next;

    pc_next_sel #(
        .RESET_VECTOR (RESET_VECTOR),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_pc_next_sel (
        .i_rst     (rst),
        .i_sel     (w_pcsel),
        .i_pc      (r_pc),
        .i_target  (redirect_target),
        .o_pc_next (w_pc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_VECTOR;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_cnt     <= '0;
            r_run     <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_latch) begin
                r_inst    <= imem_rdata;
                r_inst_pc <= r_pc;
            end
            if (w_xfer) begin
                r_cnt <= r_cnt + DATA_WIDTH'(1);
            end
        end
    end

    // Overriding events are checked before the per-state behaviour, so a
    // coincident imem_ready or inst_ready is dropped whenever one fires.
    always_comb begin
        w_state_next = r_state;
        w_pcsel      = PCSEL_HOLD;
        w_latch      = 1'b0;
        w_xfer       = 1'b0;
        if (trap) begin
            w_state_next = S_FETCH;
            w_pcsel      = PCSEL_TRAP;
        end else if (r_state != S_HALTED && redirect) begin
            w_state_next = S_FETCH;
            w_pcsel      = PCSEL_REDIR;
        end else if (r_state != S_HALTED && halt) begin
            w_state_next = S_HALTED;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_run && imem_ready) begin
                        w_latch      = 1'b1;
                        w_state_next = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        w_xfer       = 1'b1;
                        w_pcsel      = PCSEL_INC;
                        w_state_next = S_FETCH;
                    end
                end
                S_HALTED: w_state_next = S_HALTED;
                default:  w_state_next = S_FETCH;
            endcase
        end
    end

    assign imem_req   = r_run && (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign inst_valid = (r_state == S_ISSUE);
    assign inst_out   = r_inst;
    assign inst_pc    = r_inst_pc;
    assign pc_out     = r_pc;
    assign issue_cnt  = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        trap;
    logic        halt;
    logic [31:0] pc_out;
    logic [31:0] issue_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .trap            (trap),
        .halt            (halt),
        .pc_out          (pc_out),
        .issue_cnt       (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_target = '0; trap = 1'b0; halt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_pc", pc_out, 32'h0);
        check("rst_cnt", issue_cnt, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_inst", inst_out, 32'h0);
        check("rst_ipc", inst_pc, 32'h0);

        // Release: request appears only after the next edge
        rst = 1'b0;
        #1;
        check("rel_req_low", {31'b0, imem_req}, 32'h0);
        tick();
        check("rel_req", {31'b0, imem_req}, 32'h1);
        check("rel_addr", imem_addr, 32'h0);
        tick();
        check("wait_req", {31'b0, imem_req}, 32'h1);

        // First fetch and immediate acceptance
        imem_ready = 1'b1; imem_rdata = 32'h0000_0013; inst_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("f1_valid", {31'b0, inst_valid}, 32'h1);
        check("f1_inst", inst_out, 32'h0000_0013);
        check("f1_ipc", inst_pc, 32'h0);
        check("f1_req", {31'b0, imem_req}, 32'h0);
        tick();
        check("f1_pc", pc_out, 32'h4);
        check("f1_cnt", issue_cnt, 32'h1);
        check("f1_addr", imem_addr, 32'h4);
        check("f1_valid_drop", {31'b0, inst_valid}, 32'h0);

        // Stall in ISSUE for 3 cycles; stray imem_ready must be ignored
        inst_ready = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_ABCD;
        tick();
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'b0, inst_valid}, 32'h1);
            check("stall_inst", inst_out, 32'h0000_ABCD);
            check("stall_ipc", inst_pc, 32'h4);
            check("stall_cnt", issue_cnt, 32'h1);
            check("stall_req", {31'b0, imem_req}, 32'h0);
        end
        imem_ready = 1'b0;

        // Redirect during ISSUE with coincident inst_ready: no transfer
        redirect = 1'b1; redirect_target = 32'h0000_0203; inst_ready = 1'b1;
        tick();
        redirect = 1'b0; inst_ready = 1'b0;
        check("redir_valid", {31'b0, inst_valid}, 32'h0);
        check("redir_addr", imem_addr, 32'h0000_0200);
        check("redir_req", {31'b0, imem_req}, 32'h1);
        check("redir_cnt", issue_cnt, 32'h1);

        // Halt in FETCH wins over imem_ready
        halt = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        halt = 1'b0; imem_ready = 1'b0;
        check("halt_req", {31'b0, imem_req}, 32'h0);
        check("halt_valid", {31'b0, inst_valid}, 32'h0);
        check("halt_pc", pc_out, 32'h0000_0200);
        // Redirect ignored while halted
        redirect = 1'b1; redirect_target = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        check("halt_redir_pc", pc_out, 32'h0000_0200);
        check("halt_redir_req", {31'b0, imem_req}, 32'h0);
        tick();
        check("halt_stay_req", {31'b0, imem_req}, 32'h0);

        // Trap from HALTED
        trap = 1'b1;
        tick();
        trap = 1'b0;
        check("trap_h_pc", pc_out, 32'h0000_0100);
        check("trap_h_req", {31'b0, imem_req}, 32'h1);
        check("trap_h_addr", imem_addr, 32'h0000_0100);

        // Trap and redirect together in ISSUE
        imem_ready = 1'b1; imem_rdata = 32'h0000_0055;
        tick();
        imem_ready = 1'b0;
        check("tr_ipc", inst_pc, 32'h0000_0100);
        trap = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0300; inst_ready = 1'b1;
        tick();
        trap = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        check("tr_pc", pc_out, 32'h0000_0100);
        check("tr_valid", {31'b0, inst_valid}, 32'h0);
        check("tr_cnt", issue_cnt, 32'h1);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        check("wrap_pc0", pc_out, 32'hFFFF_FFFC);
        imem_ready = 1'b1; imem_rdata = 32'h0000_0077;
        tick();
        imem_ready = 1'b0;
        check("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_cnt", issue_cnt, 32'h2);

        // Asynchronous reset mid-FETCH at a non-reset PC
        redirect = 1'b1; redirect_target = 32'h0000_0080;
        tick();
        redirect = 1'b0;
        check("pre_arst_addr", imem_addr, 32'h0000_0080);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", pc_out, 32'h0);
        check("arst_cnt", issue_cnt, 32'h0);
        check("arst_req", {31'b0, imem_req}, 32'h0);
        #1;
        rst = 1'b0;
        tick();
        check("arst_rel_req", {31'b0, imem_req}, 32'h1);
        check("arst_rel_addr", imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
